// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC core and its per-source gateways.
package plic_pkg;

  // Gateway life cycle of one interrupt source.
  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_INSVC   = 2'd2
  } plic_gw_state_e;

  // Width of a source ID; never narrower than one bit.
  function automatic int plic_id_width(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// One interrupt gateway: level/edge detection, queued edge counter and the
// IDLE -> PENDING -> INSVC -> IDLE service cycle. The reserved source keeps
// its gateway parked in IDLE.
module plic_gateway import plic_pkg::*; #(
  parameter int EdgeCntW = 2,
  parameter bit Reserved = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           src_i,
  input  logic           le_i,
  input  logic           claim_i,
  input  logic           complete_i,
  output plic_gw_state_e state_o
);

  localparam logic [EdgeCntW-1:0] CntMax = '1;

  plic_gw_state_e      state_q, state_d;
  logic [EdgeCntW-1:0] cnt_q, cnt_d;
  logic                src_q;
  logic                rise;
  logic                cnt_inc;
  logic                cnt_dec;

  assign rise    = src_i & ~src_q;
  // Edges at saturation are dropped; level mode never counts.
  assign cnt_inc = le_i & rise & (cnt_q != CntMax) & ~Reserved;
  assign state_o = state_q;

  // Next-state logic; an IDLE edge gateway consumes one queued edge on entry to PENDING.
  always_comb begin
    state_d = state_q;
    cnt_dec = 1'b0;
    unique case (state_q)
      GW_IDLE: begin
        if (le_i) begin
          if ((cnt_q != '0) || rise) begin
            state_d = GW_PENDING;
            cnt_dec = 1'b1;
          end
        end else if (src_i) begin
          state_d = GW_PENDING;
        end
      end
      GW_PENDING: if (claim_i)    state_d = GW_INSVC;
      GW_INSVC:   if (complete_i) state_d = GW_IDLE;
      default:                    state_d = GW_IDLE;
    endcase
    if (Reserved) begin
      state_d = GW_IDLE;
      cnt_dec = 1'b0;
    end
  end

  // Counter update; an edge and a consumption in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + EdgeCntW'(1);
      2'b01:   cnt_d = cnt_q - EdgeCntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State, counter and previous-source registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= GW_IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_i;
    end
  end

endmodule

// File: rtl/plic_core.sv
// PLIC core: one gateway per source plus a registered priority arbiter per
// target. Configuration arrives on flat ports from an external register block.
//
// Strobe semantics: claim_i[t] and complete_i[t] are single-cycle strobes with
// no back-pressure. A claim acts on the ID currently shown on irq_id_o[t]; a
// complete acts on complete_id_i[t]. Each strobe only takes effect if the
// addressed gateway is in the matching state (PENDING for claim, INSVC for
// complete); otherwise it is silently dropped.
module plic_core import plic_pkg::*; #(
  parameter  int NumSrc    = 72,
  parameter  int NumTarget = 2,
  parameter  int MaxPrio   = 7,
  parameter  int EdgeCntW  = 2,
  localparam int PrioW     = $clog2(MaxPrio + 1),
  localparam int SrcW      = plic_id_width(NumSrc)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumSrc-1:0]    src_i,
  input  logic [NumSrc-1:0]    le_i,
  input  logic [PrioW-1:0]     prio_i        [NumSrc],
  input  logic [NumSrc-1:0]    ie_i          [NumTarget],
  input  logic [PrioW-1:0]     threshold_i   [NumTarget],
  input  logic [NumTarget-1:0] claim_i,
  input  logic [NumTarget-1:0] complete_i,
  input  logic [SrcW-1:0]      complete_id_i [NumTarget],
  output logic [NumSrc-1:0]    ip_o,
  output logic [NumTarget-1:0] irq_o,
  output logic [SrcW-1:0]      irq_id_o      [NumTarget]
);

  logic [NumSrc-1:0] claim_hit;
  logic [NumSrc-1:0] complete_hit;
  plic_gw_state_e    gw_state [NumSrc];

  // Fold all targets' claim/complete strobes into one hit per source; out-of-range IDs match nothing.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int s = 1; s < NumSrc; s++) begin
      for (int t = 0; t < NumTarget; t++) begin
        if (claim_i[t] && (irq_id_o[t] == SrcW'(s)))         claim_hit[s]    = 1'b1;
        if (complete_i[t] && (complete_id_i[t] == SrcW'(s))) complete_hit[s] = 1'b1;
      end
    end
  end

  for (genvar s = 0; s < NumSrc; s++) begin : g_src
    plic_gateway #(
      .EdgeCntW (EdgeCntW),
      .Reserved (s == 0)
    ) u_gateway (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .src_i      (src_i[s]),
      .le_i       (le_i[s]),
      .claim_i    (claim_hit[s]),
      .complete_i (complete_hit[s]),
      .state_o    (gw_state[s])
    );
    assign ip_o[s] = (gw_state[s] == GW_PENDING);
  end

  for (genvar t = 0; t < NumTarget; t++) begin : g_target
    logic [PrioW-1:0] best_prio;
    logic [SrcW-1:0]  best_id;
    logic [SrcW-1:0]  id_q;

    // Highest priority above threshold wins; strict compare keeps the lowest ID on ties.
    always_comb begin
      best_prio = threshold_i[t];
      best_id   = '0;
      for (int s = 1; s < NumSrc; s++) begin
        if (ip_o[s] && ie_i[t][s] && (prio_i[s] > best_prio)) begin
          best_prio = prio_i[s];
          best_id   = SrcW'(s);
        end
      end
    end

    // Single register stage for the winning ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) id_q <= '0;
      else         id_q <= best_id;
    end

    assign irq_id_o[t] = id_q;
    assign irq_o[t]    = (id_q != '0);
  end

endmodule

// File: tb/tb_plic_core.sv
// Self-checking bench for plic_core: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_plic_core;

  localparam int NS   = 12;
  localparam int NT   = 2;
  localparam int MP   = 7;
  localparam int PW   = 3;
  localparam int EW   = 2;
  localparam int SW   = 4;
  localparam int CMAX = (1 << EW) - 1;
  localparam int IDLE = 0;
  localparam int PEND = 1;
  localparam int SVC  = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0] src, le;
  logic [PW-1:0] prio [NS];
  logic [NS-1:0] ie   [NT];
  logic [PW-1:0] thr  [NT];
  logic [NT-1:0] claim, complete;
  logic [SW-1:0] cid  [NT];
  logic [NS-1:0] ip;
  logic [NT-1:0] irq;
  logic [SW-1:0] irq_id [NT];

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_state [NS];
  int m_cnt   [NS];
  int m_srcq  [NS];
  int m_id    [NT];

  plic_core #(
    .NumSrc(NS), .NumTarget(NT), .MaxPrio(MP), .EdgeCntW(EW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .le_i(le), .prio_i(prio),
    .ie_i(ie), .threshold_i(thr), .claim_i(claim), .complete_i(complete),
    .complete_id_i(cid), .ip_o(ip), .irq_o(irq), .irq_id_o(irq_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] model_ip();
    logic [NS-1:0] v;
    v = '0;
    for (int s = 0; s < NS; s++) v[s] = (m_state[s] == PEND);
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_state[s] = IDLE; m_cnt[s] = 0; m_srcq[s] = 0;
    end
    for (int t = 0; t < NT; t++) m_id[t] = 0;
  endtask

  // One clock of the reference behaviour, using the inputs held this cycle.
  task automatic model_step();
    int new_id [NT];
    int best, take;
    bit claimed, completed, rise;
    for (int t = 0; t < NT; t++) begin
      best = int'(thr[t]);
      new_id[t] = 0;
      for (int s = 1; s < NS; s++)
        if (m_state[s] == PEND && ie[t][s] && int'(prio[s]) > best) begin
          best = int'(prio[s]);
          new_id[t] = s;
        end
    end
    for (int s = 1; s < NS; s++) begin
      claimed = 0; completed = 0; take = 0;
      for (int t = 0; t < NT; t++) begin
        if (claim[t] && m_id[t] == s) claimed = 1;
        if (complete[t] && int'(cid[t]) == s) completed = 1;
      end
      rise = src[s] && (m_srcq[s] == 0);
      case (m_state[s])
        IDLE: begin
          if (le[s]) begin
            if (m_cnt[s] > 0 || rise) begin m_state[s] = PEND; take = 1; end
          end else if (src[s]) begin
            m_state[s] = PEND;
          end
        end
        PEND: if (claimed) m_state[s] = SVC;
        default: if (completed) m_state[s] = IDLE;
      endcase
      if (le[s] && rise && m_cnt[s] < CMAX) m_cnt[s] = m_cnt[s] + 1;
      m_cnt[s] = m_cnt[s] - take;
      m_srcq[s] = src[s] ? 1 : 0;
    end
    for (int t = 0; t < NT; t++) m_id[t] = new_id[t];
  endtask

  // driver tasks
  task automatic clear_inputs();
    src = '0; le = '0; claim = '0; complete = '0;
    for (int s = 0; s < NS; s++) prio[s] = '0;
    for (int t = 0; t < NT; t++) begin ie[t] = '0; thr[t] = '0; cid[t] = '0; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("ip", ip, model_ip());
    for (int t = 0; t < NT; t++) begin
      check_eq($sformatf("irq%0d", t), irq[t], (m_id[t] != 0));
      check_eq($sformatf("id%0d", t), irq_id[t], m_id[t]);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_ip", ip, 0);
    check_eq("rst_irq", irq, 0);
    for (int t = 0; t < NT; t++) check_eq("rst_id", irq_id[t], 0);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int s);
    src[s] = 1'b1; tick();
    src[s] = 1'b0; tick();
  endtask

  int repends;

  initial begin
    clear_inputs();
    do_reset();

    // level basic
    prio[5] = 3; ie[0][5] = 1'b1; src[5] = 1'b1;
    tick(); check_eq("lvl_ip_n1", ip[5], 1); check_eq("lvl_irq_n1", irq[0], 0);
    tick(); check_eq("lvl_irq_n2", irq[0], 1); check_eq("lvl_id_n2", irq_id[0], 5);
    claim[0] = 1'b1; tick(); claim[0] = 1'b0;
    check_eq("lvl_claim_ip", ip[5], 0); check_eq("lvl_claim_id_c1", irq_id[0], 5);
    tick(); check_eq("lvl_claim_id_c2", irq_id[0], 0);
    complete[0] = 1'b1; cid[0] = 4'd5; tick(); complete[0] = 1'b0;
    check_eq("lvl_cmp_ip", ip[5], 0);
    tick(); check_eq("lvl_repend", ip[5], 1);

    // edge queueing
    do_reset();
    le[9] = 1'b1; prio[9] = 4; ie[0][9] = 1'b1;
    pulse(9);
    check_eq("edge_id", irq_id[0], 9);
    claim[0] = 1'b1; tick(); claim[0] = 1'b0;
    check_eq("edge_claim_ip", ip[9], 0);
    for (int k = 0; k < 5; k++) pulse(9);
    repends = 0;
    for (int k = 0; k < 5; k++) begin
      complete[0] = 1'b1; cid[0] = 4'd9; tick(); complete[0] = 1'b0;
      tick();
      if (ip[9]) begin
        repends++;
        tick();
        claim[0] = 1'b1; tick(); claim[0] = 1'b0;
      end
    end
    check_eq("edge_repends", repends, 3);
    repeat (3) tick();
    check_eq("edge_idle", ip[9], 0);

    // arbitration
    do_reset();
    prio[3] = 2; prio[7] = 5; prio[8] = 5;
    ie[0][3] = 1'b1; ie[0][7] = 1'b1; ie[0][8] = 1'b1;
    src[3] = 1'b1; src[7] = 1'b1; src[8] = 1'b1;
    tick(); tick();
    check_eq("arb_id", irq_id[0], 7); check_eq("arb_irq", irq[0], 1);
    thr[0] = 5; tick();
    check_eq("arb_thr_irq", irq[0], 0); check_eq("arb_thr_id", irq_id[0], 0);
    thr[0] = 4; tick();
    check_eq("arb_thr4_id", irq_id[0], 7);

    // ignored events
    do_reset();
    claim[0] = 1'b1; tick(); claim[0] = 1'b0;
    check_eq("ign_claim0", ip, 0);
    prio[4] = 1; ie[0][4] = 1'b1; src[4] = 1'b1;
    tick(); check_eq("ign_pend", ip[4], 1);
    complete[0] = 1'b1; cid[0] = 4'd4; tick(); complete[0] = 1'b0;
    check_eq("ign_cmp_pend", ip[4], 1);
    check_eq("ign_id4", irq_id[0], 4);
    claim[0] = 1'b1; tick(); claim[0] = 1'b0;
    complete[0] = 1'b1; cid[0] = 4'd12; tick();
    cid[0] = 4'd15; tick(); complete[0] = 1'b0;
    tick();
    check_eq("ign_cmp_oor", ip[4], 0);

    // simultaneous events
    do_reset();
    prio[6] = 2; ie[0][6] = 1'b1; ie[1][6] = 1'b1; src[6] = 1'b1;
    tick(); tick();
    check_eq("sim_id0", irq_id[0], 6); check_eq("sim_id1", irq_id[1], 6);
    claim = 2'b11; tick(); claim = '0;
    check_eq("sim_claim_ip", ip[6], 0);
    complete[0] = 1'b1; cid[0] = 4'd6; tick(); complete[0] = 1'b0;
    tick(); check_eq("sim_single_insvc", ip[6], 1);
    tick(); check_eq("sim_id_again", irq_id[0], 6);
    claim[0] = 1'b1; complete[1] = 1'b1; cid[1] = 4'd6; tick();
    claim = '0; complete = '0;
    check_eq("sim_claim_cmp", ip[6], 0);
    tick(); check_eq("sim_stays_insvc", ip[6], 0);

    // reset mid-operation
    do_reset();
    le[9] = 1'b1; prio[9] = 4; ie[0][9] = 1'b1;
    prio[5] = 2; ie[1][5] = 1'b1; src[5] = 1'b1;
    pulse(9);
    claim[0] = 1'b1; tick(); claim[0] = 1'b0;
    pulse(9); pulse(9);
    check_eq("mid_irq1", irq[1], 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ip", ip, 0);
    check_eq("mid_rst_irq", irq, 0);
    check_eq("mid_rst_id0", irq_id[0], 0);
    check_eq("mid_rst_id1", irq_id[1], 0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check_eq("mid_quiet_ip", ip, 0);
    check_eq("mid_quiet_irq", irq, 0);

    // randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 60 == 0) begin
        le = NS'($urandom);
        for (int s = 0; s < NS; s++) prio[s] = PW'($urandom_range(0, MP));
        for (int t = 0; t < NT; t++) begin
          ie[t]  = NS'($urandom);
          thr[t] = PW'($urandom_range(0, 3));
        end
      end
      src = src ^ (NS'($urandom) & NS'($urandom) & NS'($urandom));
      for (int t = 0; t < NT; t++) begin
        claim[t]    = ($urandom_range(0, 3) == 0);
        complete[t] = ($urandom_range(0, 2) == 0);
        cid[t]      = SW'($urandom_range(0, 15));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
